// File: rtl/phys_reg_file_mp_pkg.sv
// Shared constants and types for the multi-ported physical register file.
package phys_reg_file_mp_pkg;

   localparam int NUM_PREGS = 64;
   localparam int DATA_W    = 32;
   localparam int ROB_ID_W  = 8;
   localparam int N_DISP    = 2;
   localparam int N_RD      = 2;
   localparam int N_CDB     = 2;
   localparam int PW        = $clog2(NUM_PREGS);

   typedef logic [PW-1:0] preg_idx_t;

   // One register file entry: value, producing ROB tag, and "not yet produced" flag.
   typedef struct packed {
      logic [DATA_W-1:0]   value;
      logic [ROB_ID_W-1:0] rob_id;
      logic                dep;
   } physical_reg_data_t;

   typedef struct packed {
      logic                valid;
      preg_idx_t           pd;
      logic [ROB_ID_W-1:0] rob_id;
      logic [DATA_W-1:0]   data;
   } cdb_t;

   typedef struct packed {
      logic                en;
      preg_idx_t           pd;
      logic [ROB_ID_W-1:0] rob_id;
   } disp_t;

   // A broadcast only lands on an entry still waiting for exactly that producer.
   function automatic logic cdb_qualifies(input cdb_t c, input physical_reg_data_t e);
      return c.valid && (c.pd != '0) && e.dep && (e.rob_id == c.rob_id);
   endfunction

endpackage

// File: rtl/phys_reg_file_mp_if.sv
// Bundle of dispatch, read, writeback and status signals of the register file.
interface phys_reg_file_mp_if;
   import phys_reg_file_mp_pkg::*;

   logic                                flush;
   disp_t     [N_DISP-1:0]              disp;
   cdb_t      [N_CDB-1:0]               cdb;
   preg_idx_t [N_RD-1:0]                rd_ps1;
   preg_idx_t [N_RD-1:0]                rd_ps2;
   logic      [N_RD-1:0][DATA_W-1:0]    rd_v1;
   logic      [N_RD-1:0][DATA_W-1:0]    rd_v2;
   logic      [N_RD-1:0]                rd_dep1;
   logic      [N_RD-1:0]                rd_dep2;
   logic      [N_RD-1:0][ROB_ID_W-1:0]  rd_rob1;
   logic      [N_RD-1:0][ROB_ID_W-1:0]  rd_rob2;
   logic      [PW:0]                    busy_cnt;

   // Rename/dispatch/CDB side.
   modport master (
      output flush, disp, cdb, rd_ps1, rd_ps2,
      input  rd_v1, rd_v2, rd_dep1, rd_dep2, rd_rob1, rd_rob2, busy_cnt
   );

   // Register file side.
   modport slave (
      input  flush, disp, cdb, rd_ps1, rd_ps2,
      output rd_v1, rd_v2, rd_dep1, rd_dep2, rd_rob1, rd_rob2, busy_cnt
   );

endinterface

// File: rtl/phys_reg_file_mp_preg_read_bypass.sv
// One source-operand read: registered entry, overridden by a qualifying CDB result.
module preg_read_bypass
   import phys_reg_file_mp_pkg::*;
(
   input  preg_idx_t                ps,
   input  physical_reg_data_t       entry,
   input  cdb_t [N_CDB-1:0]         cdb,
   output logic [DATA_W-1:0]        v,
   output logic                     dep,
   output logic [ROB_ID_W-1:0]      rob
);

   // Highest-index qualifying broadcast to this preg supplies the value.
   always_comb begin
      v   = entry.value;
      dep = entry.dep;
      rob = entry.rob_id;
      if (ps == '0) begin
         v   = '0;
         dep = 1'b0;
         rob = '0;
      end else begin
         for (int w = 0; w < N_CDB; w++) begin
            if ((cdb[w].pd == ps) && cdb_qualifies(cdb[w], entry)) begin
               v   = cdb[w].data;
               dep = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with busy/ROB-tag tracking, CDB bypass and flush.
module phys_reg_file_mp
   import phys_reg_file_mp_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   phys_reg_file_mp_if.slave  bus
);

   physical_reg_data_t regs     [NUM_PREGS];
   physical_reg_data_t regs_nxt [NUM_PREGS];
   logic [PW:0]        busy_cnt;
   logic [PW:0]        busy_nxt;

   // Next entry state: flush beats dispatch beats CDB; later ports override earlier ones.
   always_comb begin
      regs_nxt = regs;
      if (bus.flush) begin
         for (int i = 0; i < NUM_PREGS; i++) regs_nxt[i].dep = 1'b0;
      end else begin
         for (int w = 0; w < N_CDB; w++) begin
            if (cdb_qualifies(bus.cdb[w], regs[bus.cdb[w].pd])) begin
               regs_nxt[bus.cdb[w].pd] = '{value:  bus.cdb[w].data,
                                           rob_id: regs[bus.cdb[w].pd].rob_id,
                                           dep:    1'b0};
            end
         end
         // Dispatch keeps the pre-cycle value even when a CDB hits the same preg.
         for (int d = 0; d < N_DISP; d++) begin
            if (bus.disp[d].en && (bus.disp[d].pd != '0)) begin
               regs_nxt[bus.disp[d].pd] = '{value:  regs[bus.disp[d].pd].value,
                                            rob_id: bus.disp[d].rob_id,
                                            dep:    1'b1};
            end
         end
      end
   end

   // Busy count is the population of dep bits in the next state, so it moves with the array.
   always_comb begin
      busy_nxt = '0;
      for (int i = 0; i < NUM_PREGS; i++) busy_nxt = busy_nxt + {{PW{1'b0}}, regs_nxt[i].dep};
   end

   // State array and busy count; async reset wipes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PREGS; i++) regs[i] <= '0;
         busy_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_PREGS; i++) regs[i] <= regs_nxt[i];
         busy_cnt <= busy_nxt;
      end
   end

   // Flag two dispatch ports naming the same destination in one cycle.
   always_ff @(posedge clk) begin
      if (rst && !bus.flush) begin
         for (int a = 0; a < N_DISP; a++) begin
            for (int b = a + 1; b < N_DISP; b++) begin
               assert (!(bus.disp[a].en && bus.disp[b].en && (bus.disp[a].pd == bus.disp[b].pd)))
                  else $warning("duplicate dispatch destination preg %0d", bus.disp[a].pd);
            end
         end
      end
   end

   logic [DATA_W-1:0]   v1   [N_RD];
   logic [DATA_W-1:0]   v2   [N_RD];
   logic                dep1 [N_RD];
   logic                dep2 [N_RD];
   logic [ROB_ID_W-1:0] rob1 [N_RD];
   logic [ROB_ID_W-1:0] rob2 [N_RD];

   for (genvar r = 0; r < N_RD; r++) begin : g_rd
      preg_read_bypass u_rs1 (
         .ps    (bus.rd_ps1[r]),
         .entry (regs[bus.rd_ps1[r]]),
         .cdb   (bus.cdb),
         .v     (v1[r]),
         .dep   (dep1[r]),
         .rob   (rob1[r])
      );
      preg_read_bypass u_rs2 (
         .ps    (bus.rd_ps2[r]),
         .entry (regs[bus.rd_ps2[r]]),
         .cdb   (bus.cdb),
         .v     (v2[r]),
         .dep   (dep2[r]),
         .rob   (rob2[r])
      );
      assign bus.rd_v1[r]   = v1[r];
      assign bus.rd_v2[r]   = v2[r];
      assign bus.rd_dep1[r] = dep1[r];
      assign bus.rd_dep2[r] = dep2[r];
      assign bus.rd_rob1[r] = rob1[r];
      assign bus.rd_rob2[r] = rob2[r];
   end

   assign bus.busy_cnt = busy_cnt;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Scoreboard bench for phys_reg_file_mp: directed scenarios then randomized traffic.
module tb_phys_reg_file_mp;
   import phys_reg_file_mp_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   phys_reg_file_mp_if bus ();
   phys_reg_file_mp dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [N_RD-1:0][DATA_W-1:0]   v1;
      logic [N_RD-1:0][DATA_W-1:0]   v2;
      logic [N_RD-1:0]               d1;
      logic [N_RD-1:0]               d2;
      logic [N_RD-1:0][ROB_ID_W-1:0] r1;
      logic [N_RD-1:0][ROB_ID_W-1:0] r2;
      logic [PW:0]                   busy;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: plain arrays holding what each preg should contain.
   logic [DATA_W-1:0]   m_val [NUM_PREGS];
   logic [ROB_ID_W-1:0] m_rob [NUM_PREGS];
   bit                  m_dep [NUM_PREGS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM_PREGS; i++) begin
         m_val[i] = '0;
         m_rob[i] = '0;
         m_dep[i] = 1'b0;
      end
   endfunction

   // What a read of preg ps returns this cycle given current CDB traffic.
   function automatic void model_read(input preg_idx_t ps, output logic [DATA_W-1:0] v,
                                      output bit d, output logic [ROB_ID_W-1:0] rb);
      v = m_val[ps]; d = m_dep[ps]; rb = m_rob[ps];
      if (ps == 0) begin
         v = '0; d = 1'b0; rb = '0;
      end else if (m_dep[ps]) begin
         for (int w = 0; w < N_CDB; w++)
            if (bus.cdb[w].valid && bus.cdb[w].pd == ps && bus.cdb[w].rob_id == m_rob[ps])
               v = bus.cdb[w].data;
         for (int w = 0; w < N_CDB; w++)
            if (bus.cdb[w].valid && bus.cdb[w].pd == ps && bus.cdb[w].rob_id == m_rob[ps])
               d = 1'b0;
      end
   endfunction

   // Apply one clock edge worth of rules to the model.
   function automatic void model_update();
      logic [DATA_W-1:0]   nv [NUM_PREGS];
      logic [ROB_ID_W-1:0] nr [NUM_PREGS];
      bit                  nd [NUM_PREGS];
      if (!rst) begin
         model_reset();
         return;
      end
      if (bus.flush) begin
         for (int i = 0; i < NUM_PREGS; i++) m_dep[i] = 1'b0;
         return;
      end
      nv = m_val; nr = m_rob; nd = m_dep;
      for (int w = 0; w < N_CDB; w++) begin
         int p = int'(bus.cdb[w].pd);
         if (bus.cdb[w].valid && p != 0 && m_dep[p] && m_rob[p] == bus.cdb[w].rob_id) begin
            nv[p] = bus.cdb[w].data;
            nd[p] = 1'b0;
         end
      end
      for (int d = 0; d < N_DISP; d++) begin
         int p = int'(bus.disp[d].pd);
         if (bus.disp[d].en && p != 0) begin
            nv[p] = m_val[p];
            nr[p] = bus.disp[d].rob_id;
            nd[p] = 1'b1;
         end
      end
      m_val = nv; m_rob = nr; m_dep = nd;
   endfunction

   task automatic clear_inputs();
      bus.flush  = 1'b0;
      bus.disp   = '0;
      bus.cdb    = '0;
      bus.rd_ps1 = '0;
      bus.rd_ps2 = '0;
   endtask

   task automatic push_expected();
      exp_t e;
      logic [DATA_W-1:0]   v;
      bit                  d;
      logic [ROB_ID_W-1:0] rb;
      int                  c = 0;
      for (int r = 0; r < N_RD; r++) begin
         model_read(bus.rd_ps1[r], v, d, rb);
         e.v1[r] = v; e.d1[r] = d; e.r1[r] = rb;
         model_read(bus.rd_ps2[r], v, d, rb);
         e.v2[r] = v; e.d2[r] = d; e.r2[r] = rb;
      end
      for (int i = 0; i < NUM_PREGS; i++) c += int'(m_dep[i]);
      e.busy = (PW+1)'(c);
      sb.push_back(e);
   endtask

   // Inputs are already set (posedge+1); record expectation, take the edge, advance the model.
   task automatic step();
      push_expected();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [63:0] pack_rd(input logic [DATA_W-1:0] v, input logic d,
                                          input logic [ROB_ID_W-1:0] rb, input logic keep_rob);
      return 64'({v, d, keep_rob ? rb : {ROB_ID_W{1'b0}}});
   endfunction

   // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int r = 0; r < N_RD; r++) begin
               check($sformatf("sb_rs1_port%0d", r),
                     pack_rd(bus.rd_v1[r], bus.rd_dep1[r], bus.rd_rob1[r], e.d1[r]),
                     pack_rd(e.v1[r], e.d1[r], e.r1[r], e.d1[r]));
               check($sformatf("sb_rs2_port%0d", r),
                     pack_rd(bus.rd_v2[r], bus.rd_dep2[r], bus.rd_rob2[r], e.d2[r]),
                     pack_rd(e.v2[r], e.d2[r], e.r2[r], e.d2[r]));
            end
            check("sb_busy_cnt", 64'(bus.busy_cnt), 64'(e.busy));
         end
      end
   end

   task automatic rand_inputs();
      clear_inputs();
      for (int d = 0; d < N_DISP; d++) begin
         if ($urandom_range(1) == 1) begin
            bus.disp[d].en     = 1'b1;
            bus.disp[d].pd     = preg_idx_t'($urandom_range(NUM_PREGS-1));
            bus.disp[d].rob_id = ROB_ID_W'($urandom);
            for (int k = 0; k < d; k++)
               if (bus.disp[k].en && bus.disp[k].pd == bus.disp[d].pd)
                  bus.disp[d].pd = bus.disp[d].pd + preg_idx_t'(1);
         end
      end
      for (int w = 0; w < N_CDB; w++) begin
         if ($urandom_range(2) != 0) begin
            preg_idx_t p = preg_idx_t'($urandom_range(NUM_PREGS-1));
            for (int t = 0; t < 8; t++)
               if (!m_dep[p]) p = preg_idx_t'($urandom_range(NUM_PREGS-1));
            bus.cdb[w].valid  = 1'b1;
            bus.cdb[w].pd     = p;
            bus.cdb[w].rob_id = ($urandom_range(4) == 0) ? ROB_ID_W'($urandom) : m_rob[p];
            bus.cdb[w].data   = DATA_W'($urandom);
         end
      end
      bus.flush = ($urandom_range(39) == 0);
      for (int r = 0; r < N_RD; r++) begin
         bus.rd_ps1[r] = ($urandom_range(1) == 1) ? bus.cdb[$urandom_range(N_CDB-1)].pd
                                                 : preg_idx_t'($urandom_range(NUM_PREGS-1));
         bus.rd_ps2[r] = preg_idx_t'($urandom_range(NUM_PREGS-1));
      end
   endtask

   initial begin
      rst = 1'b0;
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1;

      // Reset: preg 5 reads zero, nothing busy.
      bus.rd_ps1[0] = preg_idx_t'(5);
      #1;
      check("reset_rd5", pack_rd(bus.rd_v1[0], bus.rd_dep1[0], '0, 1'b0), 64'd0);
      check("reset_busy", 64'(bus.busy_cnt), 64'd0);
      step();
      rst = 1'b1;

      // Dispatch then matching CDB, with same-cycle bypass.
      clear_inputs();
      bus.disp[0] = '{en: 1'b1, pd: preg_idx_t'(7), rob_id: 8'h12};
      step();
      clear_inputs();
      bus.cdb[0]    = '{valid: 1'b1, pd: preg_idx_t'(7), rob_id: 8'h12, data: 32'hDEADBEEF};
      bus.rd_ps1[0] = preg_idx_t'(7);
      #1;
      check("bypass_rd7", pack_rd(bus.rd_v1[0], bus.rd_dep1[0], '0, 1'b0), {23'd0, 32'hDEADBEEF, 1'b0, 8'd0});
      check("bypass_busy_before", 64'(bus.busy_cnt), 64'd1);
      step();
      clear_inputs();
      bus.rd_ps1[0] = preg_idx_t'(7);
      #1;
      check("written_rd7", pack_rd(bus.rd_v1[0], bus.rd_dep1[0], '0, 1'b0), {23'd0, 32'hDEADBEEF, 1'b0, 8'd0});
      check("written_busy", 64'(bus.busy_cnt), 64'd0);
      step();

      // Stale tag is dropped.
      clear_inputs();
      bus.disp[1] = '{en: 1'b1, pd: preg_idx_t'(9), rob_id: 8'h03};
      step();
      clear_inputs();
      bus.cdb[1]    = '{valid: 1'b1, pd: preg_idx_t'(9), rob_id: 8'h04, data: 32'h55};
      bus.rd_ps2[1] = preg_idx_t'(9);
      step();
      clear_inputs();
      bus.rd_ps2[1] = preg_idx_t'(9);
      #1;
      check("stale_rd9", pack_rd(bus.rd_v2[1], bus.rd_dep2[1], bus.rd_rob2[1], 1'b1), {23'd0, 32'd0, 1'b1, 8'h03});
      step();

      // Dispatch collision on preg 4: higher port wins.
      clear_inputs();
      bus.disp[0] = '{en: 1'b1, pd: preg_idx_t'(4), rob_id: 8'h01};
      bus.disp[1] = '{en: 1'b1, pd: preg_idx_t'(4), rob_id: 8'h02};
      step();
      clear_inputs();
      bus.rd_ps1[1] = preg_idx_t'(4);
      #1;
      check("collide_rd4", pack_rd(bus.rd_v1[1], bus.rd_dep1[1], bus.rd_rob1[1], 1'b1), {23'd0, 32'd0, 1'b1, 8'h02});
      step();

      // Flush with a qualifying CDB to preg 11.
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         bus.disp[0] = '{en: 1'b1, pd: preg_idx_t'(11 + 2*i), rob_id: ROB_ID_W'(8'h20 + 2*i)};
         bus.disp[1] = '{en: 1'b1, pd: preg_idx_t'(12 + 2*i), rob_id: ROB_ID_W'(8'h21 + 2*i)};
         step();
      end
      clear_inputs();
      bus.flush     = 1'b1;
      bus.cdb[0]    = '{valid: 1'b1, pd: preg_idx_t'(11), rob_id: 8'h20, data: 32'hCAFE0011};
      bus.rd_ps1[0] = preg_idx_t'(11);
      #1;
      check("flush_busy_before", 64'(bus.busy_cnt), 64'd12);
      check("flush_cycle_bypass", pack_rd(bus.rd_v1[0], bus.rd_dep1[0], '0, 1'b0), {23'd0, 32'hCAFE0011, 1'b0, 8'd0});
      step();
      clear_inputs();
      bus.rd_ps1[0] = preg_idx_t'(11);
      #1;
      check("flush_rd11", pack_rd(bus.rd_v1[0], bus.rd_dep1[0], '0, 1'b0), 64'd0);
      check("flush_busy_after", 64'(bus.busy_cnt), 64'd0);
      step();

      // Preg 0 ignores dispatch and CDB.
      clear_inputs();
      bus.disp[0]   = '{en: 1'b1, pd: preg_idx_t'(0), rob_id: 8'h05};
      bus.cdb[1]    = '{valid: 1'b1, pd: preg_idx_t'(0), rob_id: 8'h05, data: 32'h1};
      bus.rd_ps1[0] = preg_idx_t'(0);
      bus.rd_ps2[0] = preg_idx_t'(0);
      step();
      clear_inputs();
      #1;
      check("preg0_rd", pack_rd(bus.rd_v1[0], bus.rd_dep1[0], bus.rd_rob1[0], 1'b1), 64'd0);
      check("preg0_busy", 64'(bus.busy_cnt), 64'd0);
      step();

      // Randomized traffic, including one asynchronous reset mid-run.
      for (int n = 0; n < 1500; n++) begin
         rand_inputs();
         if (n == 700) begin
            rst = 1'b0;
            model_reset();
         end
         step();
         rst = 1'b1;
      end

      clear_inputs();
      repeat (3) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
